// File: rtl/axi4lite_master_bridge.sv
// axi4lite_master_bridge
// Turns one request at a time from the NPU-side request port into an AXI4-Lite
// transaction toward the data-memory slave, then returns read data and error
// status on the response port.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata,
//   req_wstrb                         request fields, latched on acceptance
//   rsp_valid/rsp_ready               response handshake
//   rsp_rdata, rsp_err                read data (0 for writes), slave error flag
//   m_aw*, m_w*, m_b*, m_ar*, m_r*    AXI4-Lite master channels
//   state_dbg                         current FSM state, for observation only
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid && ready are both high; a valid, once raised, stays high (with stable
// payload) until that edge.

module axi4lite_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,

    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,

    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,

    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,

    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,

    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_WB   = 3'd2,
        S_RA   = 3'd3,
        S_RD   = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    req_ready_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    accept;

    assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write ? S_WR : S_RA;
                end
            end
            S_WR: begin
                // AW and W run independently so a slave that waits for AW
                // before raising wready (or the reverse) cannot deadlock us.
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if (!aw_done_q && m_awready) aw_done_d = 1'b1;
                if (!w_done_q && m_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)   state_d   = S_WB;
            end
            S_WB: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    err_d   = (m_bresp != 2'b00);
                    rdata_d = '0;
                    state_d = S_RSP;
                end
            end
            S_RA: begin
                m_arvalid = 1'b1;
                if (m_arready) state_d = S_RD;
            end
            S_RD: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    err_d   = (m_rresp != 2'b00);
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            // Registered so it stays low for the cycle right after reset and
            // rises the cycle after a response handshake.
            req_ready_q <= (state_d == S_IDLE);
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_awprot  = 3'b000;
    assign m_arprot  = 3'b000;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
module tb_axi4lite_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [2:0]  m_awprot, m_arprot, state_dbg;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    axi4lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    // smode: 0 RAM (W ready only after AW), 1 AW ready only after W,
    //        2 both ready at once, 3 stall AW/W/AR
    int          smode     = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] mem [0:63];
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, viol = 0;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;

    initial begin
        logic aw_got, w_got, b_arm, b_pend, r_pend;
        logic aw_hs, w_hs, ar_hs;
        logic p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs, p_rst;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        aw_got = 0; w_got = 0; b_arm = 0; b_pend = 0; r_pend = 0;
        p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0; p_rst = 1;
        s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0; s_rdata = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(posedge clk);
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            ar_hs = m_arvalid && m_arready;
            // a valid dropped without its handshake is a protocol violation
            if (!rst && !p_rst) begin
                if (p_awv && !p_awhs && !m_awvalid) viol++;
                if (p_wv && !p_whs && !m_wvalid) viol++;
                if (p_arv && !p_arhs && !m_arvalid) viol++;
            end
            p_awv = m_awvalid; p_awhs = aw_hs; p_wv = m_wvalid; p_whs = w_hs;
            p_arv = m_arvalid; p_arhs = ar_hs; p_rst = rst;
            if (rst) begin
                aw_got = 0; w_got = 0; b_arm = 0; b_pend = 0; r_pend = 0;
            end else begin
                if (aw_hs) begin aw_got = 1; s_awaddr = m_awaddr; aw_cnt++; end
                if (w_hs) begin w_got = 1; s_wdata = m_wdata; s_wstrb = m_wstrb; w_cnt++; end
                if (b_pend && m_bready) begin b_pend = 0; b_cnt++; end
                if (r_pend && m_rready) r_pend = 0;
                if (b_arm) begin b_arm = 0; b_pend = 1; end
                if (aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    aw_got = 0; w_got = 0; b_arm = 1;
                end
                if (ar_hs) begin s_araddr = m_araddr; s_rdata = mem[m_araddr[7:2]]; r_pend = 1; end
            end
            #1;
            case (smode)
                0: begin m_awready = 1; m_wready = aw_got; end
                1: begin m_wready = 1; m_awready = w_got; end
                2: begin m_awready = 1; m_wready = 1; end
                default: begin m_awready = 0; m_wready = 0; end
            endcase
            m_arready = (smode != 3);
            m_bvalid  = b_pend;
            m_bresp   = b_pend ? bresp_cfg : 2'b00;
            m_rvalid  = r_pend;
            m_rdata   = r_pend ? s_rdata : 32'h0;
            m_rresp   = r_pend ? rresp_cfg : 2'b00;
        end
    end

    // ---------------- driver ----------------
    // Called #1 after a rising edge; returns #1 after the response handshake edge.
    // lat = edges from acceptance to the first edge that sees rsp_valid.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int hold,
                          output logic [31:0] rd, output logic er, output int lat);
        bit seen;
        int k;
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            if (req_ready) seen = 1;
        end
        check("req_accept", {31'b0, seen}, 1);
        #1 req_valid = 0;
        seen = 0; k = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            k++;
            if (rsp_valid) seen = 1;
        end
        check("rsp_seen", {31'b0, seen}, 1);
        lat = k; rd = rsp_rdata; er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            check("hold_rsp_valid", {31'b0, rsp_valid}, 1);
            check("hold_rsp_rdata", rsp_rdata, rd);
            check("hold_rsp_err", {31'b0, rsp_err}, {31'b0, er});
            check("hold_req_ready", {31'b0, req_ready}, 0);
            check("hold_axi_valids", {29'b0, m_awvalid, m_wvalid, m_arvalid}, 0);
        end
        #1 rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("req_ready_after_rsp", {31'b0, req_ready}, 1);
        check("idle_after_rsp", {29'b0, state_dbg}, 0);
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rd_v;
    logic        er_v;
    int          lat_v, aw0, w0, b0;

    initial begin
        rst = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        req_wstrb = 0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_axi_valids", {27'b0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        check("rst_state", {29'b0, state_dbg}, 0);
        check("rst_awaddr", m_awaddr, 0);
        rst = 0;
        check("post_rst_req_ready", {31'b0, req_ready}, 0);
        @(posedge clk); #1;
        check("req_ready_rise", {31'b0, req_ready}, 1);

        // full write, AW-then-W RAM
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd_v, er_v, lat_v);
        check("wr1_rdata", rd_v, 0);
        check("wr1_err", {31'b0, er_v}, 0);
        check("wr1_lat", lat_v, 5);
        check("wr1_aw_count", aw_cnt - aw0, 1);
        check("wr1_w_count", w_cnt - w0, 1);
        check("wr1_b_count", b_cnt - b0, 1);
        check("wr1_awaddr", s_awaddr, 32'h10);

        do_req(0, 32'h10, 32'h0, 4'h0, 0, rd_v, er_v, lat_v);
        check("rd1_rdata", rd_v, 32'hDEADBEEF);
        check("rd1_err", {31'b0, er_v}, 0);
        check("rd1_lat", lat_v, 3);
        check("rd1_araddr", s_araddr, 32'h10);

        // partial strobe merge
        do_req(1, 32'h10, 32'h0000AAAA, 4'h3, 0, rd_v, er_v, lat_v);
        check("wr2_wstrb", {28'b0, s_wstrb}, 32'h3);
        do_req(0, 32'h10, 32'h0, 4'h0, 0, rd_v, er_v, lat_v);
        check("rd2_rdata", rd_v, 32'hDEADAAAA);

        // W accepted before AW
        smode = 1;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        do_req(1, 32'h20, 32'h11223344, 4'hF, 0, rd_v, er_v, lat_v);
        check("wfirst_lat", lat_v, 5);
        check("wfirst_aw_count", aw_cnt - aw0, 1);
        check("wfirst_w_count", w_cnt - w0, 1);
        check("wfirst_b_count", b_cnt - b0, 1);
        check("wfirst_err", {31'b0, er_v}, 0);
        smode = 0;
        do_req(0, 32'h20, 32'h0, 4'h0, 0, rd_v, er_v, lat_v);
        check("wfirst_readback", rd_v, 32'h11223344);

        // AW and W in the same cycle, zero strobe still issued
        smode = 2;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
        do_req(1, 32'h24, 32'h55667788, 4'h0, 0, rd_v, er_v, lat_v);
        check("both_lat", lat_v, 4);
        check("both_aw_count", aw_cnt - aw0, 1);
        check("both_w_count", w_cnt - w0, 1);
        check("both_b_count", b_cnt - b0, 1);
        smode = 0;
        do_req(0, 32'h24, 32'h0, 4'h0, 0, rd_v, er_v, lat_v);
        check("zero_strb_readback", rd_v, 32'h0);

        // slave error responses
        bresp_cfg = 2'b10;
        do_req(1, 32'h28, 32'hCAFEF00D, 4'hF, 0, rd_v, er_v, lat_v);
        check("bresp_err", {31'b0, er_v}, 1);
        check("bresp_rdata", rd_v, 0);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b11;
        do_req(0, 32'h20, 32'h0, 4'h0, 0, rd_v, er_v, lat_v);
        check("rresp_err", {31'b0, er_v}, 1);
        check("rresp_rdata", rd_v, 32'h11223344);
        rresp_cfg = 2'b00;

        // response back-pressure
        do_req(1, 32'h30, 32'h12345678, 4'hF, 0, rd_v, er_v, lat_v);
        do_req(0, 32'h30, 32'h0, 4'h0, 5, rd_v, er_v, lat_v);
        check("hold_read_rdata", rd_v, 32'h12345678);
        check("hold_read_err", {31'b0, er_v}, 0);

        // reset while stuck in WR
        smode = 3;
        req_valid = 1; req_write = 1; req_addr = 32'h34; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        @(posedge clk);
        check("rst_test_accept", {31'b0, req_ready}, 1);
        #1 req_valid = 0;
        @(posedge clk); #1;
        check("wr_stall_awvalid", {31'b0, m_awvalid}, 1);
        check("wr_stall_wvalid", {31'b0, m_wvalid}, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("midrst_awvalid", {31'b0, m_awvalid}, 0);
        check("midrst_wvalid", {31'b0, m_wvalid}, 0);
        check("midrst_req_ready", {31'b0, req_ready}, 0);
        check("midrst_state", {29'b0, state_dbg}, 0);
        smode = 0;
        @(posedge clk); #1;
        check("midrst_req_ready_rise", {31'b0, req_ready}, 1);
        do_req(0, 32'h10, 32'h0, 4'h0, 0, rd_v, er_v, lat_v);
        check("post_rst_read", rd_v, 32'hDEADAAAA);
        check("post_rst_lat", lat_v, 3);
        do_req(0, 32'h34, 32'h0, 4'h0, 0, rd_v, er_v, lat_v);
        check("aborted_write_absent", rd_v, 32'h0);

        check("protocol_violations", viol, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4lite_master_bridge.md
# axi4lite_master_bridge

Single-outstanding request/response port to AXI4-Lite master bridge. NPU-side logic (load/store unit, DMA sequencer) presents one 32-bit read or write per request. The bridge turns it into a compliant AXI4-Lite transaction toward the data-memory slave and returns read data and error status. It sits directly upstream of the AXI4-Lite data RAM and drives all five of its channels.

## Interface
- ADDR_WIDTH, 32, byte-address width on request port and AXI
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_write  in  1  1 = write, 0 = read
- req_addr, req_wdata, req_wstrb  in  ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  request fields
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_rdata, rsp_err  out  DATA_WIDTH, 1  read data (0 for writes); 1 if slave resp != OKAY
- m_awaddr, m_awprot, m_awvalid out ADDR_WIDTH/3/1; m_awready in 1  write address channel
- m_wdata, m_wstrb, m_wvalid out DATA_WIDTH/DATA_WIDTH/8/1; m_wready in 1  write data channel
- m_bresp, m_bvalid in 2/1; m_bready out 1  write response channel
- m_araddr, m_arprot, m_arvalid out ADDR_WIDTH/3/1; m_arready in 1  read address channel
- m_rdata, m_rresp, m_rvalid in DATA_WIDTH/2/1; m_rready out 1  read data channel

## Operation
- FSM states: IDLE, WR (AW+W), WB (B wait), RA (AR), RD (R wait), RSP.
- IDLE: req_ready=1. On req_valid&&req_ready latch write/addr/wdata/wstrb, go to WR (write) or RA (read).
- WR: m_awvalid and m_wvalid both asserted. Each drops individually after its own handshake (flags aw_done, w_done). m_wvalid must not wait on m_awready. The bridge must tolerate a slave that raises m_wready only after AW is accepted. When both flags are set, go to WB. Both handshakes in the same cycle is legal and goes straight to WB.
- WB: m_bready=1. On m_bvalid latch rsp_err = (m_bresp != 2'b00), set rsp_rdata=0, go to RSP.
- RA: m_arvalid=1 until m_arready; then go to RD.
- RD: m_rready=1. On m_rvalid latch rsp_rdata=m_rdata and rsp_err = (m_rresp != 2'b00), go to RSP.
- RSP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready; then go to IDLE.
- req_ready=0 in every state except IDLE. No AXI valid is asserted in IDLE or RSP.
- Addresses and strobes pass unmodified: no alignment or masking. A write with wstrb=0 is still issued.
- m_awprot and m_arprot are tied to 3'b000. m_awaddr/m_wdata/m_wstrb/m_araddr are held from the latched request, stable while the matching valid is high.
- AXI rule: once asserted, a valid is never withdrawn before its handshake.

## Timing
- While rst is high, and on the cycle after it: all outputs 0 and state IDLE. req_ready rises in the first cycle with rst low.
- Request accepted at edge N: AXI valids are registered and high from cycle N+1.
- Read against a zero-wait slave: AR handshake at N+1, R at N+2, rsp_valid at N+3.
- Write against the RAM (W accepted only after AW): AW at N+1, W at N+2, B at N+4, rsp_valid at N+5.
- rsp_valid is registered and rises the cycle after the B or R handshake.
- After rsp handshake at edge M: req_ready=1 at M+1. Back-to-back requests therefore have at least one IDLE cycle between them.
- Reset asserted mid-transaction: at the next edge all valids and ready outputs go to 0 and state goes to IDLE, with no completion of the in-flight transfer. The slave is reset in the same domain.

## Test plan
- Write 0xDEADBEEF to 0x10 with wstrb 0xF, then read 0x10 -> read returns rsp_rdata=0xDEADBEEF with rsp_err=0; write returns rsp_rdata=0 with rsp_err=0.
- Write 0x0000AAAA to 0x10 with wstrb 0x3 over the previous value, then read -> rsp_rdata=0xDEADAAAA.
- Slave delays m_wready until after AW, and separately asserts m_wready before m_awready -> both orderings complete. m_awvalid drops right after its handshake while m_wvalid is held, and exactly one B is consumed.
- Slave returns bresp=2'b10 on a write and rresp=2'b11 on a read -> rsp_err=1 both times; FSM returns to IDLE.
- rsp_ready held low 5 cycles after a read of 0x12345678 -> rsp_valid and rsp_rdata stable throughout, req_ready=0, no AXI valid asserted.
- rst pulsed for 1 cycle while in WR with m_awready low -> m_awvalid and m_wvalid are 0 next cycle, req_ready=1 the following cycle, and a subsequent read completes normally.
